// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encoding and PWM width.
// PWM_W is used only when the design is built with LED_DIM_EN.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_R  = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_t;

    localparam int PWM_W = 3;

    // BLINK seeds all-off; every other mode seeds a single lit bit 0.
    function automatic logic seed_is_one(input led_mode_t m);
        return m != MODE_BLINK;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: one step every (TICK_CYCLES >> speed) enabled cycles.
// The >= compare clamps cnt when speed is raised past the current count.
module led_tick_gen #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic [1:0] speed,
    input  logic       clr,
    output logic       step
);

    localparam logic [CNT_W:0] TICK_FULL = TICK_CYCLES[CNT_W:0];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   last;

    always_comb begin
        last = (TICK_FULL >> speed) - 1'b1;
    end

    assign step = en && !clr && ({1'b0, cnt} >= last);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= step ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator: rotate/bounce/blink patterns stepped by led_tick_gen.
// Optional LED_DIM_EN adds a bright[2:0] input and 3-bit PWM dimming on led.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_NUM     = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
`ifdef LED_DIM_EN
    input  logic [PWM_W-1:0]   bright,
`endif
    output logic [LED_NUM-1:0] led,
    output logic               step
);

    localparam logic [LED_NUM-1:0] SEED = {{(LED_NUM-1){1'b0}}, 1'b1};

    led_mode_t          mode_in;
    led_mode_t          mode_q;
    logic               mode_chg;
    logic               tick;
    logic [LED_NUM-1:0] pat;
    logic [LED_NUM-1:0] pat_nxt;
    logic               dir_up;
    logic               dir_nxt;
    logic               step_nxt;

    assign mode_in  = led_mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);

    // A mode change clears the prescaler, so it reloads instead of stepping.
    led_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .speed   (speed),
        .clr     (mode_chg),
        .step    (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mode_q <= MODE_ROT_R;
            pat    <= SEED;
            dir_up <= 1'b1;
            step   <= 1'b0;
        end else begin
            mode_q <= mode_in;
            pat    <= pat_nxt;
            dir_up <= dir_nxt;
            step   <= step_nxt;
        end
    end

    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir_up;
        if (mode_chg) begin
            pat_nxt = seed_is_one(mode_in) ? SEED : '0;
            dir_nxt = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_ROT_R: pat_nxt = {pat[0], pat[LED_NUM-1:1]};
                MODE_ROT_L: pat_nxt = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
                MODE_BOUNCE: begin
                    if (dir_up) begin
                        pat_nxt = pat << 1;
                        if (pat_nxt[LED_NUM-1])
                            dir_nxt = 1'b0;
                    end else begin
                        pat_nxt = pat >> 1;
                        if (pat_nxt[0])
                            dir_nxt = 1'b1;
                    end
                end
                default: pat_nxt = ~pat;
            endcase
            // A blank pattern left over from BLINK would never recover by shifting.
            if (mode_q != MODE_BLINK && pat == '0) begin
                pat_nxt = SEED;
                dir_nxt = 1'b1;
            end
        end
    end

`ifdef LED_DIM_EN
    logic [PWM_W-1:0]   pwm_cnt;
    logic [LED_NUM-1:0] led_nxt;
    logic [LED_NUM-1:0] led_r;

    always_comb begin
        step_nxt = tick;
        led_nxt  = pat_nxt & {LED_NUM{pwm_cnt < bright}};
    end

    // Masking the next pattern keeps led aligned with the step pulse.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pwm_cnt <= '0;
            led_r   <= SEED;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_r   <= led_nxt;
        end
    end

    assign led = led_r;
`else
    always_comb begin
        step_nxt = tick;
    end

    assign led = pat;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (LED_NUM=4, TICK_CYCLES=10): stimulus
// queues cycle-stamped expectations, a negedge monitor pops and compares.
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int TC = 10;

    typedef struct {
        int           cyc;
        logic [N-1:0] led;
        logic         step;
        int           tag;
    } exp_t;

    exp_t q[$];

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic         en      = 1'b0;
    logic [1:0]   mode    = 2'd0;
    logic [1:0]   speed   = 2'd0;
    logic [N-1:0] led;
    logic         step;
`ifdef LED_DIM_EN
    logic [2:0]   bright  = 3'd7;
    logic [2:0]   pwm_m;
    logic         lit_m;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int tag    = 0;

    led_sequencer #(
        .LED_NUM     (N),
        .TICK_CYCLES (TC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .mode    (mode),
        .speed   (speed),
`ifdef LED_DIM_EN
        .bright  (bright),
`endif
        .led     (led),
        .step    (step)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

`ifdef LED_DIM_EN
    // Duty reference: lit for bright out of every 8 cycles.
    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pwm_m <= 3'd0;
            lit_m <= 1'b1;
        end else begin
            lit_m <= (pwm_m < bright);
            pwm_m <= pwm_m + 3'd1;
        end
    end
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_at(input int ofs, input logic [N-1:0] l, input logic s);
        exp_t e;
        e.cyc  = cyc + ofs;
        e.led  = l;
        e.step = s;
        e.tag  = tag;
        tag    = tag + 1;
        q.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        exp_t         e;
        logic [N-1:0] el;
        logic         stepped;
        stepped = 1'b0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            el = e.led;
`ifdef LED_DIM_EN
            if (sys_rst) el = el & {N{lit_m}};
`endif
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL chk%0d missed: due cycle %0d, now %0d", e.tag, e.cyc, cyc);
            end else begin
                if (e.step) stepped = 1'b1;
                if (led !== el || step !== e.step) begin
                    errors++;
                    $display("FAIL chk%0d cycle %0d: led=%b step=%b, expected led=%b step=%b",
                             e.tag, cyc, led, step, el, e.step);
                end
            end
        end
        if (step === 1'b1 && !stepped) begin
            checks++;
            errors++;
            $display("FAIL stray_step cycle %0d: step=1 led=%b, expected step=0", cyc, led);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] bseq [8];
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

        // Reset state, then ROT_R at speed 0
        sys_rst = 1'b0; en = 1'b1; mode = 2'd0; speed = 2'd0;
        expect_at(1, 4'b0001, 1'b0);
        tick(2);
        sys_rst = 1'b1;
        expect_at(10, 4'b1000, 1'b1);
        expect_at(20, 4'b0100, 1'b1);
        expect_at(30, 4'b0010, 1'b1);
        expect_at(40, 4'b0001, 1'b1);
        tick(40);

        // BOUNCE for 8 steps; reload cycle first
        mode = 2'd2;
        expect_at(1, 4'b0001, 1'b0);
        for (int i = 0; i < 8; i++)
            expect_at(11 + 10 * i, bseq[i], 1'b1);
        tick(87);

        // Speed 0 -> 3 at cnt = 6: step every cycle, then speed 1 every 5
        speed = 2'd3;
        expect_at(1, 4'b1000, 1'b1);
        expect_at(2, 4'b0100, 1'b1);
        expect_at(3, 4'b0010, 1'b1);
        expect_at(4, 4'b0001, 1'b1);
        expect_at(5, 4'b0010, 1'b1);
        expect_at(6, 4'b0100, 1'b1);
        tick(6);
        speed = 2'd1;
        expect_at(5, 4'b1000, 1'b1);
        expect_at(10, 4'b0100, 1'b1);
        tick(10);

        // BLINK, then ROT_L entered from the all-off state
        speed = 2'd0; mode = 2'd3;
        expect_at(1, 4'b0000, 1'b0);
        expect_at(11, 4'b1111, 1'b1);
        expect_at(21, 4'b0000, 1'b1);
        tick(21);
        mode = 2'd1;
        expect_at(1, 4'b0001, 1'b0);
        expect_at(11, 4'b0010, 1'b1);
        tick(11);

        // Pause at cnt = 4 for 20 cycles, resume, then async reset mid-period
        tick(4);
        en = 1'b0;
        expect_at(6, 4'b0010, 1'b0);
        expect_at(20, 4'b0010, 1'b0);
        tick(20);
        en = 1'b1;
        expect_at(6, 4'b0100, 1'b1);
        tick(9);
        sys_rst = 1'b0; mode = 2'd0;
        expect_at(0, 4'b0001, 1'b0);
        tick(2);
        en = 1'b0; sys_rst = 1'b1;
        expect_at(1, 4'b0001, 1'b0);
        expect_at(8, 4'b0001, 1'b0);
        tick(8);

`ifdef LED_DIM_EN
        bright = 3'd3;
        for (int i = 1; i <= 16; i++)
            expect_at(i, 4'b0001, 1'b0);
        tick(16);
        bright = 3'd0;
        for (int i = 1; i <= 8; i++)
            expect_at(i, 4'b0000, 1'b0);
        tick(8);
        bright = 3'd7;
`endif

        en = 1'b1;
        expect_at(10, 4'b1000, 1'b1);
        tick(14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
